// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-field helpers for the data-cache controller.
// No logic or state; the helpers take the geometry as arguments so parameterised users stay consistent.
package dcache_pkg;

    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 5;
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
    localparam int BLOCK_W  = 256;
    localparam int WSEL_W   = 3;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w, input int offset_w);
        return addr >> (index_w + offset_w);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w, input int offset_w);
        return (addr >> offset_w) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_word(input logic [31:0] addr, input int offset_w);
        return (addr >> 2) & ((32'd1 << (offset_w - 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage {valid, dirty, tag, block}: asynchronous read, synchronous refill or per-word store.
// Reset clears valid/dirty only; tag and block contents are don't-care until refilled.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 22
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_block,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_block,
    input  logic               store_en,
    input  logic [WSEL_W-1:0]  store_word,
    input  logic [31:0]        store_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q   [LINES];
    logic [BLOCK_W-1:0] block_q [LINES];

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_block = block_q[index];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (store_en) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Refill and store never coincide: stores only happen on an IDLE hit.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[index]   <= fill_tag;
            block_q[index] <= fill_block;
        end else if (store_en) begin
            block_q[index][{store_word, 5'b0} +: 32] <= store_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller: hits in 0 cycles, misses stall the pipeline.
// Memory-side outputs come from the state register and a latched miss address, so they hold for the whole transaction.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_W  = dcache_pkg::INDEX_W,
    parameter int OFFSET_W = dcache_pkg::OFFSET_W,
    parameter int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               p1_req_i,
    input  logic               p1_write_i,
    input  logic [31:0]        p1_addr_i,
    input  logic [31:0]        p1_data_i,
    output logic [31:0]        p1_data_o,
    output logic               p1_stall_o,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    output logic [BLOCK_W-1:0] mem_data_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i
);

    state_t             state_q, state_d;
    logic [31:0]        miss_addr_q;
    logic [31:0]        cur_addr;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [WSEL_W-1:0]  req_word;
    logic               rd_valid, rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic [BLOCK_W-1:0] rd_block;
    logic               hit, idle_hit, store_en, fill_en;

    // During a miss the latched address drives the line, so a dropped request cannot disturb it.
    assign cur_addr  = (state_q == IDLE) ? p1_addr_i : miss_addr_q;
    assign req_tag   = TAG_W'(addr_tag(cur_addr, INDEX_W, OFFSET_W));
    assign req_index = INDEX_W'(addr_index(cur_addr, INDEX_W, OFFSET_W));
    assign req_word  = WSEL_W'(addr_word(cur_addr, OFFSET_W));

    assign hit        = rd_valid && (rd_tag == req_tag);
    assign idle_hit   = (state_q == IDLE) && hit;
    assign p1_stall_o = p1_req_i && !idle_hit;
    assign p1_data_o  = idle_hit ? rd_block[{req_word, 5'b0} +: 32] : 32'd0;
    assign store_en   = idle_hit && p1_req_i && p1_write_i;
    assign fill_en    = (state_q == READMISS) && mem_ack_i;

    dcache_sram #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .index      (req_index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_block   (rd_block),
        .fill_en    (fill_en),
        .fill_tag   (req_tag),
        .fill_block (mem_data_i),
        .store_en   (store_en),
        .store_word (req_word),
        .store_data (p1_data_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && p1_req_i && !hit) begin
                miss_addr_q <= p1_addr_i;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (p1_req_i && !hit) state_d = MISS;
            end
            MISS: begin
                state_d = rd_dirty ? WRITEBACK : READMISS;
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_tag, req_index, {OFFSET_W{1'b0}}};
                mem_data_o   = rd_block;
                if (mem_ack_i) state_d = READMISS;
            end
            READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {req_tag, req_index, {OFFSET_W{1'b0}}};
                if (mem_ack_i) state_d = READMISSOK;
            end
            READMISSOK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hit/miss/writeback sequencing, ack timing, reset abort, dropped request.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         p1_req_i;
    logic         p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_req_i     (p1_req_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] blk;
        logic         stable;

        rst_i = 1'b1; p1_req_i = 1'b0; p1_write_i = 1'b0;
        p1_addr_i = '0; p1_data_i = '0; mem_data_i = '0; mem_ack_i = 1'b0;
        step(); step(); #1;
        chk("rst_mem_en",   mem_enable_o, 1'b0);
        chk("rst_mem_wr",   mem_write_o,  1'b0);
        chk("rst_mem_addr", mem_addr_o,   32'h0);
        chk("rst_mem_data", mem_data_o,   256'h0);
        chk("rst_stall_noreq", p1_stall_o, 1'b0);
        p1_req_i = 1'b1; p1_addr_i = 32'h0000_0400; #1;
        chk("rst_stall_req", p1_stall_o, 1'b1);
        rst_i = 1'b0;

        // Clean miss on 0x400, ack in the third READMISS cycle.
        step(); #1;
        chk("miss_stall", p1_stall_o, 1'b1);
        chk("miss_no_en", mem_enable_o, 1'b0);
        step(); #1;
        chk("rm_en",   mem_enable_o, 1'b1);
        chk("rm_wr",   mem_write_o,  1'b0);
        chk("rm_addr", mem_addr_o,   32'h0000_0400);
        step(); step();
        blk = '0; blk[31:0] = 32'h1111_0000; blk[63:32] = 32'hDEAD_BEEF;
        mem_data_i = blk; mem_ack_i = 1'b1;
        step(); mem_ack_i = 1'b0; #1;
        chk("ack_en_drop", mem_enable_o, 1'b0);
        chk("rmok_stall",  p1_stall_o,   1'b1);
        step(); #1;
        chk("hit_w0_stall", p1_stall_o, 1'b0);
        chk("hit_w0_data",  p1_data_o,  32'h1111_0000);
        p1_addr_i = 32'h0000_0404; #1;
        chk("hit_w1_data",  p1_data_o,  32'hDEAD_BEEF);
        chk("hit_w1_stall", p1_stall_o, 1'b0);

        // Store hit followed directly by a load.
        p1_write_i = 1'b1; p1_addr_i = 32'h0000_0408; p1_data_i = 32'h1234_5678; #1;
        chk("st_hit_stall", p1_stall_o, 1'b0);
        step(); p1_write_i = 1'b0; #1;
        chk("ld_after_st_data",  p1_data_o,  32'h1234_5678);
        chk("ld_after_st_stall", p1_stall_o, 1'b0);

        // Dirty conflict miss: writeback of tag 1, ack held off, then refill of tag 2.
        p1_addr_i = 32'h0000_0808; #1;
        chk("dmiss_stall", p1_stall_o, 1'b1);
        chk("dmiss_data0", p1_data_o,  32'h0);
        step(); step(); #1;
        chk("wb_en",    mem_enable_o,       1'b1);
        chk("wb_wr",    mem_write_o,        1'b1);
        chk("wb_addr",  mem_addr_o,         32'h0000_0400);
        chk("wb_word2", mem_data_o[95:64],  32'h1234_5678);
        chk("wb_word1", mem_data_o[63:32],  32'hDEAD_BEEF);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h0000_0400)
                stable = 1'b0;
        end
        chk("wb_hold_stable", stable, 1'b1);
        mem_ack_i = 1'b1;
        step(); mem_ack_i = 1'b0; #1;
        chk("rm2_en",   mem_enable_o, 1'b1);
        chk("rm2_wr",   mem_write_o,  1'b0);
        chk("rm2_addr", mem_addr_o,   32'h0000_0800);
        chk("rm2_data0", mem_data_o,  256'h0);
        blk = '0; blk[95:64] = 32'hCAFE_0002; blk[31:0] = 32'hCAFE_0000;
        mem_data_i = blk; mem_ack_i = 1'b1;
        step(); mem_ack_i = 1'b0;
        step(); #1;
        chk("dmiss_hit_stall", p1_stall_o, 1'b0);
        chk("dmiss_hit_data",  p1_data_o,  32'hCAFE_0002);

        // Spurious ack in IDLE must not refill or start a transaction.
        p1_req_i = 1'b0; mem_data_i = '1; mem_ack_i = 1'b1;
        step(); mem_ack_i = 1'b0; #1;
        chk("spur_en",    mem_enable_o, 1'b0);
        chk("spur_stall", p1_stall_o,   1'b0);
        p1_req_i = 1'b1; #1;
        chk("spur_hit_data",  p1_data_o,  32'hCAFE_0002);
        chk("spur_hit_stall", p1_stall_o, 1'b0);

        // Reset while in READMISS aborts and invalidates.
        p1_addr_i = 32'h0000_0400; #1;
        chk("rmrst_miss_stall", p1_stall_o, 1'b1);
        step(); step(); #1;
        chk("rmrst_rm_en", mem_enable_o, 1'b1);
        rst_i = 1'b1;
        step(); rst_i = 1'b0; #1;
        chk("rmrst_en_off", mem_enable_o, 1'b0);
        chk("rmrst_stall",  p1_stall_o,   1'b1);
        step(); #1;
        chk("rmrst_miss_en", mem_enable_o, 1'b0);
        step(); #1;
        chk("rmrst_rm_en2",  mem_enable_o, 1'b1);
        chk("rmrst_rm_wr",   mem_write_o,  1'b0);
        chk("rmrst_rm_addr", mem_addr_o,   32'h0000_0400);
        blk = '0; blk[31:0] = 32'h7777_0000;
        mem_data_i = blk; mem_ack_i = 1'b1;
        step(); mem_ack_i = 1'b0;
        step(); #1;
        chk("rmrst_hit_data",  p1_data_o,  32'h7777_0000);
        chk("rmrst_hit_stall", p1_stall_o, 1'b0);

        // Dirty the line, then drop the request during WRITEBACK.
        p1_write_i = 1'b1; p1_data_i = 32'h55AA_55AA; #1;
        chk("st2_stall", p1_stall_o, 1'b0);
        step(); p1_write_i = 1'b0;
        p1_addr_i = 32'h0000_0800; #1;
        chk("drop_miss_stall", p1_stall_o, 1'b1);
        step(); step(); #1;
        chk("drop_wb_en", mem_enable_o, 1'b1);
        chk("drop_wb_wr", mem_write_o,  1'b1);
        p1_req_i = 1'b0; #1;
        chk("drop_wb_stall", p1_stall_o, 1'b0);
        step(); #1;
        chk("drop_wb_word0", mem_data_o[31:0], 32'h55AA_55AA);
        chk("drop_wb_addr",  mem_addr_o,       32'h0000_0400);
        mem_ack_i = 1'b1;
        step(); mem_ack_i = 1'b0; #1;
        chk("drop_rm_en",    mem_enable_o, 1'b1);
        chk("drop_rm_addr",  mem_addr_o,   32'h0000_0800);
        chk("drop_rm_stall", p1_stall_o,   1'b0);
        blk = '0; blk[31:0] = 32'h8888_0000;
        mem_data_i = blk; mem_ack_i = 1'b1;
        step(); mem_ack_i = 1'b0;
        step(); #1;
        chk("drop_idle_en",    mem_enable_o, 1'b0);
        chk("drop_idle_stall", p1_stall_o,   1'b0);
        p1_req_i = 1'b1; #1;
        chk("drop_hit_stall", p1_stall_o, 1'b0);
        chk("drop_hit_data",  p1_data_o,  32'h8888_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
